// File: rtl/pdecoder24_hold.sv
// Registered 2-to-4 decoder with a per-code hold time, a one-deep pending buffer
// and a sticky error flag for codes that were dropped.
module pdecoder24_hold #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic I1,
  input  logic I2,
  input  logic V,
  output logic O1,
  output logic O2,
  output logic O3,
  output logic O4,
  output logic BUSY,
  output logic ERR
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_code_q, pend_code_d;
  logic        err_q, err_d;
  logic [3:0]  onehot_q, onehot_d;
  logic        busy_q, busy_d;
  logic [1:0]  code_in;

  assign code_in = {I2, I1};

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (V) begin
          state_d = ACTIVE;
          code_d  = code_in;
          cnt_d   = RELOAD;
        end
      end
      ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (V) begin
            if (!pend_vld_q) begin
              pend_vld_d  = 1'b1;
              pend_code_d = code_in;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (pend_vld_q) begin
          // Final hold cycle: pending slot drains while a new code may refill it.
          code_d     = pend_code_q;
          cnt_d      = RELOAD;
          pend_vld_d = V;
          if (V) pend_code_d = code_in;
        end else if (V) begin
          code_d = code_in;
          cnt_d  = RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    onehot_d = '0;
    if (state_d == ACTIVE) onehot_d[code_d] = 1'b1;
    busy_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
      err_q       <= 1'b0;
      onehot_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      err_q       <= err_d;
      onehot_q    <= onehot_d;
      busy_q      <= busy_d;
    end
  end

  assign O1   = onehot_q[0];
  assign O2   = onehot_q[1];
  assign O3   = onehot_q[2];
  assign O4   = onehot_q[3];
  assign BUSY = busy_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_pdecoder24_hold.sv
// Directed bench for pdecoder24_hold: a HOLD=4 instance for hold/pending/error
// behaviour and a HOLD=1 instance for the one-code-per-cycle stream.
module tb_pdecoder24_hold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic i1_a, i2_a, v_a;
  logic o1_a, o2_a, o3_a, o4_a, busy_a, err_a;
  logic i1_b, i2_b, v_b;
  logic o1_b, o2_b, o3_b, o4_b, busy_b, err_b;

  int total = 0;
  int bad   = 0;

  pdecoder24_hold #(.HOLD(4), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .I1(i1_a), .I2(i2_a), .V(v_a),
    .O1(o1_a), .O2(o2_a), .O3(o3_a), .O4(o4_a), .BUSY(busy_a), .ERR(err_a)
  );

  pdecoder24_hold #(.HOLD(1), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .I1(i1_b), .I2(i2_b), .V(v_b),
    .O1(o1_b), .O2(o2_b), .O3(o3_b), .O4(o4_b), .BUSY(busy_b), .ERR(err_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; v_a = 1'b1; {i2_a, i1_a} = 2'b11; v_b = 1'b1; {i2_b, i1_b} = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      v_a = 1'b0; v_b = 1'b0;
      total++;
      if ({o4_a, o3_a, o2_a, o1_a, busy_a, err_a} !== 6'b0) begin
        bad++;
        $display("FAIL reset_a cyc=%0d got=%b want=000000", i, {o4_a, o3_a, o2_a, o1_a, busy_a, err_a});
      end
      total++;
      if ({o4_b, o3_b, o2_b, o1_b, busy_b, err_b} !== 6'b0) begin
        bad++;
        $display("FAIL reset_b cyc=%0d got=%b want=000000", i, {o4_b, o3_b, o2_b, o1_b, busy_b, err_b});
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    logic [3:0] exp [6];
    exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    v_a = 1'b1; {i2_a, i1_a} = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick();
      v_a = 1'b0;
      total++;
      if ({o4_a, o3_a, o2_a, o1_a} !== exp[i] || busy_a !== (|exp[i]) || err_a !== 1'b0) begin
        bad++;
        $display("FAIL single cyc=%0d got=%b busy=%b err=%b want=%b", i, {o4_a, o3_a, o2_a, o1_a}, busy_a, err_a, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp [10];
    logic       vin [10];
    logic [1:0] cin [10];
    exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    vin = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cin = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 10; i++) begin
      v_a = vin[i]; {i2_a, i1_a} = cin[i];
      tick();
      total++;
      if ({o4_a, o3_a, o2_a, o1_a} !== exp[i] || busy_a !== (|exp[i]) || err_a !== 1'b0) begin
        bad++;
        $display("FAIL b2b cyc=%0d got=%b busy=%b err=%b want=%b", i, {o4_a, o3_a, o2_a, o1_a}, busy_a, err_a, exp[i]);
      end
    end
    v_a = 1'b0;
  endtask

  task automatic test_overflow;
    logic [3:0] exp [12];
    logic       vin [3];
    logic [1:0] cin [3];
    exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
            4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vin = '{1'b1, 1'b1, 1'b1};
    cin = '{2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 12; i++) begin
      if (i < 3) begin
        v_a = vin[i]; {i2_a, i1_a} = cin[i];
      end else begin
        v_a = 1'b0; {i2_a, i1_a} = 2'b00;
      end
      tick();
      total++;
      if ({o4_a, o3_a, o2_a, o1_a} !== exp[i] || busy_a !== (|exp[i])) begin
        bad++;
        $display("FAIL overflow_out cyc=%0d got=%b busy=%b want=%b", i, {o4_a, o3_a, o2_a, o1_a}, busy_a, exp[i]);
      end
      total++;
      if (err_a !== (i >= 2)) begin
        bad++;
        $display("FAIL overflow_err cyc=%0d got=%b want=%b", i, err_a, (i >= 2));
      end
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1; v_a = 1'b0;
    tick();
    rst = 1'b0;
    total++;
    if (err_a !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err_a);
    end
    v_a = 1'b1; {i2_a, i1_a} = 2'b11;
    tick();
    total++;
    if ({o4_a, o3_a, o2_a, o1_a} !== 4'b1000 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL mid_load got=%b busy=%b want=1000", {o4_a, o3_a, o2_a, o1_a}, busy_a);
    end
    v_a = 1'b1; {i2_a, i1_a} = 2'b00;
    tick();
    v_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({o4_a, o3_a, o2_a, o1_a, busy_a, err_a} !== 6'b0) begin
      bad++;
      $display("FAIL mid_reset got=%b want=000000", {o4_a, o3_a, o2_a, o1_a, busy_a, err_a});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({o4_a, o3_a, o2_a, o1_a, busy_a} !== 5'b0) begin
        bad++;
        $display("FAIL mid_after cyc=%0d got=%b want=00000", i, {o4_a, o3_a, o2_a, o1_a, busy_a});
      end
    end
  endtask

  task automatic test_hold1_stream;
    logic [3:0] exp [7];
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        v_b = 1'b1; {i2_b, i1_b} = 2'(i);
      end else begin
        v_b = 1'b0; {i2_b, i1_b} = 2'b00;
      end
      tick();
      total++;
      if ({o4_b, o3_b, o2_b, o1_b} !== exp[i] || busy_b !== (|exp[i]) || err_b !== 1'b0) begin
        bad++;
        $display("FAIL hold1 cyc=%0d got=%b busy=%b err=%b want=%b", i, {o4_b, o3_b, o2_b, o1_b}, busy_b, err_b, exp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    v_a = 1'b0; i1_a = 1'b0; i2_a = 1'b0;
    v_b = 1'b0; i1_b = 1'b0; i2_b = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_hold1_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
